// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, opcodes
// and datapath select values.
package mc_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_RS1  = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MDR   = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the control FSM (master) and the multi-cycle
// datapath/memory (slave).
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       halt_req;
  logic       pc_write;
  logic       pc_write_cond;
  logic       lorD;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic       pc_source;
  logic       write_enable;
  logic       ALUsrc_A;
  logic [1:0] ALUsrc_B;
  logic [1:0] aluop;
  logic       is_halted;
  logic [2:0] cur_state;

  modport master (
    input  opcode, bcond, mem_ready, halt_req,
    output pc_write, pc_write_cond, lorD, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, write_enable, ALUsrc_A, ALUsrc_B, aluop,
           is_halted, cur_state
  );

  modport slave (
    output opcode, bcond, mem_ready, halt_req,
    input  pc_write, pc_write_cond, lorD, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, write_enable, ALUsrc_A, ALUsrc_B, aluop,
           is_halted, cur_state
  );
endinterface

// File: rtl/mc_perf_counters.sv
// Free-running active-cycle and retired-instruction counters; both wrap
// modulo 2^CNT_W.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (active) cycle_count <= cycle_count + 1'b1;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM driving all datapath enables and selects.
// Define MC_CTRL_PERF_EN to build the cycle/instruction performance counters.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);

  state_t state_q, state_d;
  logic   mem_done;
  logic   next_seq;

  assign mem_done      = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign bus.cur_state = state_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // NOTE: every output gets a default first; a missed branch then yields 0
  // instead of an inferred latch.
  always_comb begin
    state_d           = state_q;
    next_seq          = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.lorD          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = M2R_ALU;
    bus.pc_source     = 1'b0;
    bus.write_enable  = 1'b0;
    bus.ALUsrc_A      = SRCA_PC;
    bus.ALUsrc_B      = SRCB_RS2;
    bus.aluop         = ALUOP_ADD;
    bus.is_halted     = 1'b0;

    case (state_q)
      S_INIT: state_d = S_IF;

      S_IF: begin
        bus.mem_read = 1'b1;
        bus.ir_write = mem_done;
        if (mem_done) state_d = S_ID;
      end

      // ALUOut captures PC+imm here for branches and JAL
      S_ID: begin
        bus.ALUsrc_B = SRCB_IMM;
        case (bus.opcode)
          OP_ECALL: begin
            if (bus.halt_req) state_d = S_HALT;
            else begin
              next_seq = 1'b1;
              state_d  = S_IF;
            end
          end
          OP_JAL: state_d = S_WB;
          OP_R, OP_I, OP_LW, OP_SW, OP_BRANCH, OP_JALR: state_d = S_EX;
          default: begin
            next_seq = 1'b1;
            state_d  = S_IF;
          end
        endcase
      end

      S_EX: begin
        bus.ALUsrc_A = SRCA_RS1;
        state_d      = S_WB;
        case (bus.opcode)
          OP_R: bus.aluop = ALUOP_R;
          OP_I: begin
            bus.ALUsrc_B = SRCB_IMM;
            bus.aluop    = ALUOP_I;
          end
          OP_LW, OP_SW: begin
            bus.ALUsrc_B = SRCB_IMM;
            state_d      = S_MEM;
          end
          OP_JALR: bus.ALUsrc_B = SRCB_IMM;
          OP_BRANCH: begin
            bus.aluop         = ALUOP_BR;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 1'b1;
            state_d           = bus.bcond ? S_IF : S_WB;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        bus.lorD = 1'b1;
        state_d  = S_IF;
        if (bus.opcode == OP_SW) begin
          bus.mem_write = 1'b1;
          next_seq      = mem_done;
          if (!mem_done) state_d = S_MEM;
        end else if (bus.opcode == OP_LW) begin
          bus.mem_read = 1'b1;
          state_d      = mem_done ? S_WB : S_MEM;
        end
      end

      S_WB: begin
        state_d = S_IF;
        case (bus.opcode)
          OP_R, OP_I: begin
            bus.write_enable = 1'b1;
            next_seq         = 1'b1;
          end
          OP_LW: begin
            bus.write_enable = 1'b1;
            bus.mem_to_reg   = M2R_MDR;
            next_seq         = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            bus.write_enable = 1'b1;
            bus.mem_to_reg   = M2R_PC4;
            bus.pc_write     = 1'b1;
            bus.pc_source    = 1'b1;
          end
          OP_BRANCH: next_seq = 1'b1;
          default: ;
        endcase
      end

      S_HALT: bus.is_halted = 1'b1;

      default: state_d = S_INIT;
    endcase

    // Sequential fall-through: PC <= PC + 4 straight from the ALU
    if (next_seq) begin
      bus.pc_write  = 1'b1;
      bus.ALUsrc_A  = SRCA_PC;
      bus.ALUsrc_B  = SRCB_FOUR;
      bus.pc_source = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic active, retire;
  assign active = (state_q != S_INIT) && (state_q != S_HALT);
  assign retire = ((state_d == S_IF) && (state_q inside {S_ID, S_EX, S_MEM, S_WB})) ||
                  ((state_d == S_HALT) && (state_q != S_HALT));

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .retire      (retire),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected traces built from the
// state/output rules, replayed cycle by cycle with randomized don't-care inputs.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [2:0] ST_INIT = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2,
                         ST_EX = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LW = 7'b0000011,
                         T_SW = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_SYS = 7'b1110011, T_LUI = 7'b0110111;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_SYS, K_UNK} kind_t;

  typedef struct packed {
    logic       pc_write, pc_write_cond, lord, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg;
    logic       pc_source, write_enable, src_a;
    logic [1:0] src_b, aluop;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic [2:0] st;
    ctl_t       c;
    logic [6:0] op;
    logic       mr, bc, hr, retire;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  step_t plan[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_cyc = 0;
  int m_ins = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      T_R:    return K_R;
      T_I:    return K_I;
      T_LW:   return K_LW;
      T_SW:   return K_SW;
      T_BR:   return K_BR;
      T_JAL:  return K_JAL;
      T_JALR: return K_JALR;
      T_SYS:  return K_SYS;
      default: return K_UNK;
    endcase
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.lord          = bus.lorD;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.pc_source     = bus.pc_source;
    o.write_enable  = bus.write_enable;
    o.src_a         = bus.ALUsrc_A;
    o.src_b         = bus.ALUsrc_B;
    o.aluop         = bus.aluop;
    o.halted        = bus.is_halted;
    return o;
  endfunction

  task automatic push(input logic [2:0] st, input ctl_t c, input logic [6:0] op,
                      input logic mr, input logic bc, input logic hr, input logic retire);
    step_t s;
    s.st = st; s.c = c; s.op = op; s.mr = mr; s.bc = bc; s.hr = hr; s.retire = retire;
    plan.push_back(s);
  endtask

  // Expected cycle trace of one instruction; IR is not yet valid during IF.
  task automatic plan_instr(input logic [6:0] op, input logic taken, input logic halt,
                            input int if_wait, input int mem_wait);
    kind_t k;
    ctl_t  c;
    k = kind_of(op);
    for (int i = 0; i < if_wait; i++) begin
      c = '0; c.mem_read = 1'b1;
      push(ST_IF, c, 7'($urandom), 1'b0, rb(), rb(), 1'b0);
    end
    c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1;
    push(ST_IF, c, 7'($urandom), 1'b1, rb(), rb(), 1'b0);

    c = '0; c.src_b = 2'b10;
    if (k == K_SYS && halt) begin
      push(ST_ID, c, op, rb(), rb(), 1'b1, 1'b1);
      return;
    end
    if (k == K_SYS || k == K_UNK) begin
      c.pc_write = 1'b1; c.src_b = 2'b01;
      push(ST_ID, c, op, rb(), rb(), (k == K_SYS) ? 1'b0 : rb(), 1'b1);
      return;
    end
    push(ST_ID, c, op, rb(), rb(), rb(), 1'b0);

    if (k != K_JAL) begin
      c = '0; c.src_a = 1'b1;
      case (k)
        K_R:  c.aluop = 2'b10;
        K_I:  begin c.src_b = 2'b10; c.aluop = 2'b11; end
        K_BR: begin c.aluop = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1; end
        default: c.src_b = 2'b10;
      endcase
      push(ST_EX, c, op, rb(), (k == K_BR) ? taken : rb(), rb(), (k == K_BR) && taken);
      if (k == K_BR && taken) return;
    end

    if (k == K_LW || k == K_SW) begin
      c = '0; c.lord = 1'b1;
      if (k == K_LW) c.mem_read = 1'b1;
      else           c.mem_write = 1'b1;
      for (int i = 0; i < mem_wait; i++) push(ST_MEM, c, op, 1'b0, rb(), rb(), 1'b0);
      if (k == K_SW) begin
        c.pc_write = 1'b1; c.src_b = 2'b01;
        push(ST_MEM, c, op, 1'b1, rb(), rb(), 1'b1);
        return;
      end
      push(ST_MEM, c, op, 1'b1, rb(), rb(), 1'b0);
    end

    c = '0;
    case (k)
      K_R, K_I:     c.write_enable = 1'b1;
      K_LW:         begin c.write_enable = 1'b1; c.mem_to_reg = 2'b01; end
      K_JAL, K_JALR: begin
        c.write_enable = 1'b1; c.mem_to_reg = 2'b10; c.pc_write = 1'b1; c.pc_source = 1'b1;
      end
      default: ;
    endcase
    if (k inside {K_R, K_I, K_LW, K_BR}) begin
      c.pc_write = 1'b1; c.src_b = 2'b01;
    end
    push(ST_WB, c, op, rb(), rb(), rb(), 1'b1);
  endtask

  task automatic plan_halt_cycles(input int n);
    ctl_t c;
    c = '0; c.halted = 1'b1;
    for (int i = 0; i < n; i++) push(ST_HALT, c, 7'($urandom), rb(), rb(), rb(), 1'b0);
  endtask

  task automatic check_counters();
    logic [CNT_W-1:0] exp_cyc, exp_ins;
`ifdef MC_CTRL_PERF_EN
    exp_cyc = CNT_W'(m_cyc);
    exp_ins = CNT_W'(m_ins);
`else
    exp_cyc = '0;
    exp_ins = '0;
`endif
    check("cycle_count", 32'(cycle_count), 32'(exp_cyc));
    check("instr_count", 32'(instr_count), 32'(exp_ins));
  endtask

  task automatic run_plan(input int limit);
    step_t s;
    int    n;
    n = 0;
    while (plan.size() > 0 && n < limit) begin
      s = plan.pop_front();
      n++;
      @(negedge clk);
      bus.opcode    = s.op;
      bus.mem_ready = s.mr;
      bus.bcond     = s.bc;
      bus.halt_req  = s.hr;
      #1;
      check($sformatf("state op=%b", s.op), 32'(bus.cur_state), 32'(s.st));
      check($sformatf("ctl st%0d op=%b", s.st, s.op), 32'(observe()), 32'(s.c));
      check_counters();
      if (s.st != ST_INIT && s.st != ST_HALT) m_cyc++;
      if (s.retire) m_ins++;
    end
    plan.delete();
  endtask

  // Reset is raised between clock edges so its effect must be asynchronous.
  task automatic do_reset();
    ctl_t c;
    #2;
    reset = 1'b1;
    #1;
    m_cyc = 0;
    m_ins = 0;
    check("reset state", 32'(bus.cur_state), 32'(ST_INIT));
    check("reset ctl", 32'(observe()), 32'h0);
    check_counters();
    @(posedge clk);
    #2;
    reset = 1'b0;
    c = '0;
    push(ST_INIT, c, 7'($urandom), rb(), rb(), rb(), 1'b0);
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{T_R, T_I, T_LW, T_SW, T_BR, T_JAL, T_JALR, T_SYS, T_LUI};
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.bcond     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;

    do_reset();
    repeat (5) plan_instr(T_R, 1'b0, 1'b0, 0, 0);
    run_plan(1000);

    plan_instr(T_LW,   1'b0, 1'b0, 2, 3);
    plan_instr(T_BR,   1'b1, 1'b0, 0, 0);
    plan_instr(T_BR,   1'b0, 1'b0, 0, 0);
    plan_instr(T_JAL,  1'b0, 1'b0, 0, 0);
    plan_instr(T_JALR, 1'b0, 1'b0, 1, 0);
    plan_instr(T_SW,   1'b0, 1'b0, 0, 2);
    plan_instr(T_I,    1'b0, 1'b0, 0, 0);
    plan_instr(T_SYS,  1'b0, 1'b0, 0, 0);
    plan_instr(T_LUI,  1'b0, 1'b0, 1, 0);
    run_plan(1000);

    for (int i = 0; i < 80; i++)
      plan_instr(ops[$urandom_range(8)], rb(), 1'b0,
                 int'($urandom_range(3)), int'($urandom_range(3)));
    run_plan(10000);

    // Stop inside a long LW memory wait, then drop reset on it.
    do_reset();
    plan_instr(T_LW, 1'b0, 1'b0, 0, 6);
    run_plan(7);
    do_reset();

    plan_instr(T_SYS, 1'b0, 1'b1, 1, 0);
    plan_halt_cycles(20);
    run_plan(1000);
    do_reset();

    plan_instr(T_R, 1'b0, 1'b0, 0, 0);
    plan_instr(T_SW, 1'b0, 1'b0, 1, 1);
    run_plan(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle RV32I control unit with its own registered state machine. Sits between the instruction register and the multi-cycle datapath, driving every datapath enable and mux select from current state plus opcode. Next generation of the combinational control decoder:
- holds state internally
- handshakes with variable-latency memory
- resolves branches from the ALU condition
- adds JAL/JALR link write-back, a sticky halt, and optional performance counters

## Interface
Parameters:
- MEM_HANDSHAKE, 1: when 1, memory states wait for mem_ready; when 0, mem_ready is ignored and treated as 1.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears state and counters
- opcode  in  7  IR[6:0]
- bcond  in  1  branch condition from ALU, valid in EX
- mem_ready  in  1  memory completes current access this cycle
- halt_req  in  1  datapath flag: ECALL with x17 == 10
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write when bcond (datapath ORs with pc_write)
- lorD  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory request strobes, held until mem_ready
- ir_write  out  1  latch instruction into IR and MDR
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC+4
- pc_source  out  1  0 ALU result, 1 ALUOut
- write_enable  out  1  register-file write
- ALUsrc_A  out  1  0 PC, 1 rs1
- ALUsrc_B  out  2  00 rs2, 01 const 4, 10 imm
- aluop  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- is_halted  out  1  sticky halt
- cur_state  out  3  state register, for debug
- cycle_count, instr_count  out  CNT_W each  performance counters

## Operation
- States:
  - INIT=0: entered on reset; goes to IF next cycle.
  - IF=1: lorD=0, mem_read=1, ir_write=mem_ready. Stays until mem_ready, then goes to ID.
  - ID=2: ALUsrc_A=0, ALUsrc_B=10, aluop=00, so ALUOut latches PC+imm.
    - ECALL with halt_req → HALT.
    - ECALL without halt_req, or unknown opcode → pc_write=1, ALUsrc_A=0, ALUsrc_B=01, pc_source=0 (PC+4), then IF.
    - JAL → WB.
    - All others → EX.
  - EX=3, per opcode:
    - R: A=1, B=00, aluop=10 → WB.
    - I-ALU: A=1, B=10, aluop=11 → WB.
    - LW/SW: A=1, B=10, aluop=00 → MEM.
    - JALR: A=1, B=10, aluop=00 → WB.
    - BRANCH: A=1, B=00, aluop=01, pc_write_cond=1, pc_source=1. Goes to IF if bcond, else WB.
  - MEM=4: lorD=1, request held until mem_ready.
    - LW: mem_read=1, then WB.
    - SW: mem_write=1. In the mem_ready cycle also pc_write=1, A=0, B=01, pc_source=0, then IF.
  - WB=5:
    - R/I: write_enable=1, mem_to_reg=00.
    - LW: write_enable=1, mem_to_reg=01.
    - JAL/JALR: write_enable=1, mem_to_reg=10, pc_write=1, pc_source=1.
    - R/I/LW and not-taken branch: pc_write=1, A=0, B=01, pc_source=0.
    - All go to IF.
  - HALT=6: all strobes 0, is_halted=1. Exits only on reset.
  - Encoding 7 is illegal and goes to INIT.
- Control outputs are combinational from cur_state, opcode, bcond and mem_ready. Any output not listed for a state is 0.
- JALR clears target bit 0 in the datapath, not here.

## Timing
- Reset:
  - cur_state=INIT; every control output 0.
  - is_halted=0; counters 0.
  - Reset mid-access drops strobes immediately (asynchronous).
- Cycles with zero memory wait:
  - R/I/JALR: 4 (IF, ID, EX, WB).
  - LW: 5.
  - SW: 4.
  - JAL: 3.
  - Taken branch: 3.
  - Not-taken branch: 4.
  - ECALL and NOP: 2.
- Each wait cycle adds 1 in IF or MEM.
- mem_read/mem_write and lorD are held stable from request until the mem_ready cycle, inclusive.
- mem_ready outside IF/MEM is ignored.
- opcode is sampled only in ID and later states; IR is stable then.

## Configuration
- MC_CTRL_PERF_EN defined:
  - cycle_count increments every cycle where cur_state is neither INIT nor HALT.
  - instr_count increments on every transition into IF from ID, EX, MEM or WB (retire). Also counts on the transition into HALT.
  - Both wrap modulo 2^CNT_W.
- Not defined: counters are not synthesised and both outputs are constant 0.

## Structure
- Package mc_pkg holds:
  - state localparams INIT…HALT
  - opcode constants R, I-ALU, LW, SW, BRANCH, JAL, JALR, ECALL
  - aluop, ALUsrc_B and mem_to_reg encodings
- Sub-module mc_perf_counters (CNT_W, clk, reset, active, retire) is instantiated only under MC_CTRL_PERF_EN.

## Test plan
- R-type ADD (0110011), mem_ready=1 → states 1,2,3,5,1. In WB, write_enable=1, mem_to_reg=00, pc_write=1.
- LW, IF waits 2 cycles and MEM waits 3 (MEM_HANDSHAKE=1) → 10 cycles total. mem_read and lorD=1 stay high for all 4 MEM cycles; ir_write is pulsed once.
- BRANCH with bcond=1 → EX→IF, pc_write_cond=1, pc_source=1, 3 cycles. With bcond=0 → EX→WB with pc_write=1, pc_source=0.
- JAL → IF, ID, WB. In WB: mem_to_reg=10, write_enable=1, pc_write=1, pc_source=1.
- ECALL, halt_req=1 → HALT, is_halted=1, all strobes 0 for 20 cycles. Reset asserted mid-HALT → INIT, is_halted=0 asynchronously.
- MC_CTRL_PERF_EN with CNT_W=4: 5 ADDs → instr_count=5, cycle_count=20 mod 16=4. Without the macro, both read 0.
